// File: rtl/phase_bank_mv.sv
// Multi-voice phase accumulator bank: explicit (voice, note, bend) slots in,
// phase and note-on pulse out two enabled edges later.
module phase_bank_mv #(
    parameter int NVOICES = 10,
    parameter int VIDX_W  = 4,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 16,
    parameter int BEND_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              i_valid,
    input  logic [VIDX_W-1:0] i_voice,
    input  logic [6:0]        i_midi,
    input  logic [BEND_W-1:0] i_bend,
    output logic              o_valid,
    output logic [VIDX_W-1:0] o_voice,
    output logic [6:0]        o_midi,
    output logic [OUT_W-1:0]  o_phase,
    output logic              o_note_on
);
    // Valid-only stream without backpressure: every clk_en edge accepts one slot
    // (i_valid qualifies it) and emits one slot (o_valid marks an active voice).

    localparam int TW_W = PHASE_W + 2;

    // Top-octave tuning words, floor(2**24 * f / 96 kHz); lower octaves are
    // exact right shifts of these, so the floor stays exact for every note.
    function automatic logic [23:0] midi_lut(input logic [6:0] note);
        logic [7:0]  s;
        logic [3:0]  semi;
        logic [3:0]  oct;
        logic [3:0]  top_oct;
        logic [23:0] top;
        s       = {1'b0, note} + 8'd3;
        semi    = 4'(s % 8'd12);
        oct     = 4'(s / 8'd12);
        top_oct = 4'd10;
        case (semi)
            4'd0:    top = 24'd1230329;
            4'd1:    top = 24'd1303488;
            4'd2:    top = 24'd1380997;
            4'd3:    top = 24'd1463116;
            4'd4:    top = 24'd1550117;
            4'd5:    top = 24'd1642292;
            4'd6:    top = 24'd1739948;
            4'd7:    top = 24'd1843410;
            4'd8:    top = 24'd1953025;
            4'd9:    top = 24'd2069158;
            4'd10:   top = 24'd2192197;
            4'd11: begin
                top     = 24'd1161276;
                top_oct = 4'd9;
            end
            default: top = 24'd0;
        endcase
        return top >> (top_oct - oct);
    endfunction

    logic [23:0]             w_lut;
    logic [PHASE_W-1:0]      w_lut_sc;
    logic signed [TW_W-1:0]  w_sum;
    logic [PHASE_W-1:0]      w_tw;

    always_comb begin
        w_lut    = midi_lut(i_midi);
        w_lut_sc = PHASE_W'(w_lut) << (PHASE_W - 24);
        w_sum    = $signed({2'b00, w_lut_sc})
                 + $signed({{(TW_W-BEND_W){i_bend[BEND_W-1]}}, i_bend});
        // Saturate rather than wrap so a large bend can never reverse the pitch.
        if (w_sum[TW_W-1])
            w_tw = '0;
        else if (w_sum[PHASE_W])
            w_tw = '1;
        else
            w_tw = w_sum[PHASE_W-1:0];
    end

    logic                r1_valid;
    logic [VIDX_W-1:0]   r1_voice;
    logic [6:0]          r1_midi;
    logic [PHASE_W-1:0]  r1_tw;

    logic [PHASE_W-1:0]  r_phase [NVOICES];
    logic [6:0]          r_last  [NVOICES];

    logic                w_in_range;
    assign w_in_range = (int'(r1_voice) < NVOICES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_voice  <= '0;
            r1_midi   <= '0;
            r1_tw     <= '0;
            o_valid   <= 1'b0;
            o_voice   <= '0;
            o_midi    <= '0;
            o_phase   <= '0;
            o_note_on <= 1'b0;
            for (int i = 0; i < NVOICES; i++) begin
                r_phase[i] <= '0;
                r_last[i]  <= '0;
            end
        end else if (clk_en) begin
            r1_valid  <= i_valid;
            r1_voice  <= i_voice;
            r1_midi   <= i_midi;
            r1_tw     <= w_tw;
            o_voice   <= r1_voice;
            o_midi    <= r1_midi;
            o_valid   <= 1'b0;
            o_phase   <= '0;
            o_note_on <= 1'b0;
            if (r1_valid && w_in_range) begin
                if (r1_midi == 7'd0) begin
                    r_phase[r1_voice] <= '0;
                    r_last[r1_voice]  <= '0;
                end else if (r1_midi != r_last[r1_voice]) begin
                    o_valid           <= 1'b1;
                    o_note_on         <= 1'b1;
                    r_phase[r1_voice] <= r1_tw;
                    r_last[r1_voice]  <= r1_midi;
                end else begin
                    o_valid           <= 1'b1;
                    o_phase           <= r_phase[r1_voice][PHASE_W-1 -: OUT_W];
                    r_phase[r1_voice] <= r_phase[r1_voice] + r1_tw;
                end
            end
        end
    end
endmodule

// File: tb/tb_phase_bank_mv.sv
// Bench for phase_bank_mv: spec vector table, hand sequences and random slots
// checked against a real-arithmetic tuning/accumulation model.
module tb_phase_bank_mv;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        i_valid;
    logic [3:0]  i_voice;
    logic [6:0]  i_midi;
    logic [13:0] i_bend;

    logic        o_valid;
    logic [3:0]  o_voice;
    logic [6:0]  o_midi;
    logic [23:0] o_phase;
    logic        o_note_on;

    logic        o16_valid;
    logic [3:0]  o16_voice;
    logic [6:0]  o16_midi;
    logic [15:0] o16_phase;
    logic        o16_note_on;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    phase_bank_mv #(.NVOICES(10), .VIDX_W(4), .PHASE_W(24), .OUT_W(24), .BEND_W(14)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .i_voice(i_voice),
        .i_midi(i_midi), .i_bend(i_bend), .o_valid(o_valid), .o_voice(o_voice),
        .o_midi(o_midi), .o_phase(o_phase), .o_note_on(o_note_on)
    );

    phase_bank_mv #(.NVOICES(10), .VIDX_W(4), .PHASE_W(24), .OUT_W(16), .BEND_W(14)) dut16 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .i_voice(i_voice),
        .i_midi(i_midi), .i_bend(i_bend), .o_valid(o16_valid), .o_voice(o16_voice),
        .o_midi(o16_midi), .o_phase(o16_phase), .o_note_on(o16_note_on)
    );

    typedef struct packed {
        bit        valid;
        bit [3:0]  voice;
        bit [6:0]  midi;
        bit [23:0] phase;
        bit        note_on;
        bit        has_tab;
        bit        tab_valid;
        bit [23:0] tab_phase;
        bit        tab_note_on;
    } exp_t;

    typedef struct packed {
        bit        valid;
        bit [3:0]  voice;
        bit [6:0]  midi;
        bit [13:0] bend;
        bit        e_valid;
        bit [23:0] e_phase;
        bit        e_note_on;
    } vec_t;

    exp_t   exp_q[$];
    exp_t   last_exp;
    vec_t   vecs[$];
    longint m_phase[16];
    int     m_last[16];
    int     drv_note[16];

    // Reference model: tuning word from equal temperament at 96 kHz, then the
    // off / new-note / sustain rules on a per-voice phase kept modulo 2**24.
    function automatic longint model_tw(int n, int b);
        real    f;
        longint lut;
        longint tw;
        f   = 440.0 * $pow(2.0, (n - 69) / 12.0);
        lut = longint'($floor(f * 16777216.0 / 96000.0));
        tw  = lut + longint'(b);
        if (tw < 0) tw = 0;
        if (tw > 64'sd16777215) tw = 64'sd16777215;
        return tw;
    endfunction

    function automatic exp_t model_slot(bit v, bit [3:0] voice, bit [6:0] midi, bit [13:0] bend);
        exp_t e;
        int   b;
        int   vi;
        e       = '0;
        e.voice = voice;
        e.midi  = midi;
        vi      = int'(voice);
        b       = $signed(bend);
        if (!v || vi >= 10) return e;
        if (midi == 0) begin
            m_phase[vi] = 0;
            m_last[vi]  = 0;
        end else if (int'(midi) != m_last[vi]) begin
            e.valid     = 1'b1;
            e.note_on   = 1'b1;
            m_phase[vi] = model_tw(int'(midi), b);
            m_last[vi]  = int'(midi);
        end else begin
            e.valid     = 1'b1;
            e.phase     = 24'(m_phase[vi]);
            m_phase[vi] = (m_phase[vi] + model_tw(int'(midi), b)) % 64'sd16777216;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, "_valid"},   32'(o_valid),   32'(e.valid));
        check({tag, "_note_on"}, 32'(o_note_on), 32'(e.note_on));
        check({tag, "_phase"},   32'(o_phase),   32'(e.phase));
        check({tag, "_valid16"}, 32'(o16_valid), 32'(e.valid));
        check({tag, "_phase16"}, 32'(o16_phase), 32'(e.phase[23:8]));
        if (e.valid) begin
            check({tag, "_voice"}, 32'(o_voice), 32'(e.voice));
            check({tag, "_midi"},  32'(o_midi),  32'(e.midi));
        end
        if (e.has_tab) begin
            check({tag, "_tab_valid"},   32'(o_valid),   32'(e.tab_valid));
            check({tag, "_tab_phase"},   32'(o_phase),   32'(e.tab_phase));
            check({tag, "_tab_note_on"}, 32'(o_note_on), 32'(e.tab_note_on));
        end
    endtask

    task automatic slot(input bit v, input bit [3:0] voice, input bit [6:0] midi,
                        input bit [13:0] bend, input bit has_tab, input bit tv,
                        input bit [23:0] tp, input bit tn);
        exp_t e;
        e             = model_slot(v, voice, midi, bend);
        e.has_tab     = has_tab;
        e.tab_valid   = tv;
        e.tab_phase   = tp;
        e.tab_note_on = tn;
        exp_q.push_back(e);
        clk_en  = 1'b1;
        i_valid = v;
        i_voice = voice;
        i_midi  = midi;
        i_bend  = bend;
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            compare_out("slot", e);
            last_exp = e;
        end
    endtask

    task automatic mslot(input bit [3:0] voice, input bit [6:0] midi, input bit [13:0] bend);
        slot(1'b1, voice, midi, bend, 1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic hold_cycle();
        exp_t e;
        clk_en  = 1'b0;
        i_valid = 1'($urandom_range(0, 1));
        i_voice = 4'($urandom_range(0, 15));
        i_midi  = 7'($urandom_range(0, 127));
        i_bend  = 14'($urandom_range(0, 16383));
        @(posedge clk);
        #1;
        e         = last_exp;
        e.has_tab = 1'b0;
        compare_out("hold", e);
        clk_en = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_phase[i]  = 0;
            m_last[i]   = 0;
            drv_note[i] = 0;
        end
        exp_q.delete();
        last_exp = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},   32'(o_valid),   32'd0);
        check({tag, "_voice"},   32'(o_voice),   32'd0);
        check({tag, "_midi"},    32'(o_midi),    32'd0);
        check({tag, "_phase"},   32'(o_phase),   32'd0);
        check({tag, "_note_on"}, 32'(o_note_on), 32'd0);
        check({tag, "_phase16"}, 32'(o16_phase), 32'd0);
    endtask

    task automatic add_vec(input bit [3:0] voice, input bit [6:0] midi, input bit [13:0] bend,
                           input bit ev, input bit [23:0] ep, input bit en);
        vec_t t;
        t = '{valid: 1'b1, voice: voice, midi: midi, bend: bend,
              e_valid: ev, e_phase: ep, e_note_on: en};
        vecs.push_back(t);
    endtask

    initial begin
        bit [23:0] step;
        rst     = 1'b1;
        clk_en  = 1'b0;
        i_valid = 1'b0;
        i_voice = '0;
        i_midi  = '0;
        i_bend  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Note on/sustain, note change, off/retrigger, bend, clamp, wrap.
        for (int k = 0; k < 4; k++) add_vec(4'd3, 7'h45, 14'd0, 1'b1, 24'(k * 24'h012C5F), k == 0);
        add_vec(4'd3, 7'h46, 14'd0, 1'b1, 24'h000000, 1'b1);
        add_vec(4'd3, 7'h46, 14'd0, 1'b1, 24'h013E3C, 1'b0);
        add_vec(4'd3, 7'h00, 14'd0, 1'b0, 24'h000000, 1'b0);
        add_vec(4'd3, 7'h46, 14'd0, 1'b1, 24'h000000, 1'b1);
        add_vec(4'd3, 7'h45, 14'd0,  1'b1, 24'h000000, 1'b1);
        add_vec(4'd3, 7'h45, 14'd16, 1'b1, 24'h012C5F, 1'b0);
        add_vec(4'd3, 7'h45, 14'd16, 1'b1, 24'h0258CE, 1'b0);
        add_vec(4'd3, 7'h45, 14'd16, 1'b1, 24'h03853D, 1'b0);
        add_vec(4'd2, 7'h01, 14'h2000, 1'b1, 24'h000000, 1'b1);
        add_vec(4'd2, 7'h01, 14'h2000, 1'b1, 24'h000000, 1'b0);
        add_vec(4'd2, 7'h01, 14'h2000, 1'b1, 24'h000000, 1'b0);
        step = 24'h217345;
        for (int k = 0; k < 9; k++) add_vec(4'd5, 7'h7F, 14'd0, 1'b1, 24'(k * step), k == 0);
        add_vec(4'd12, 7'h45, 14'd0, 1'b0, 24'h000000, 1'b0);

        for (int i = 0; i < vecs.size(); i++)
            slot(vecs[i].valid, vecs[i].voice, vecs[i].midi, vecs[i].bend,
                 1'b1, vecs[i].e_valid, vecs[i].e_phase, vecs[i].e_note_on);

        // Interleaved voices, then back-to-back same-voice slots and a gap.
        for (int k = 0; k < 3; k++) begin
            mslot(4'd0, 7'h3C, 14'd0);
            mslot(4'd1, 7'h48, 14'd0);
        end
        mslot(4'd1, 7'h48, 14'd0);
        mslot(4'd1, 7'h48, 14'd0);
        slot(1'b0, 4'd1, 7'h48, 14'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        mslot(4'd12, 7'h48, 14'd0);
        mslot(4'd1, 7'h48, 14'd0);
        mslot(4'd0, 7'h3C, 14'd0);
        mslot(4'd3, 7'h45, 14'd16);

        // Enable low: nothing moves, then the stream resumes in step with the model.
        for (int k = 0; k < 5; k++) hold_cycle();
        mslot(4'd3, 7'h45, 14'd16);
        mslot(4'd1, 7'h48, 14'd0);

        // Asynchronous reset between edges, then a fresh note.
        rst = 1'b1;
        #2;
        check_zero("async_rst");
        rst = 1'b0;
        model_reset();
        slot(1'b1, 4'd3, 7'h45, 14'd0, 1'b1, 1'b1, 24'h000000, 1'b1);
        slot(1'b1, 4'd3, 7'h45, 14'd0, 1'b1, 1'b1, 24'h012C5F, 1'b0);
        slot(1'b1, 4'd3, 7'h45, 14'd0, 1'b1, 1'b1, 24'h0258BE, 1'b0);

        // Random slots with sticky per-voice notes so sustains are common.
        for (int n = 0; n < 400; n++) begin
            int        vi;
            int        k;
            bit [13:0] b;
            if ($urandom_range(0, 19) == 0) hold_cycle();
            vi = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            if (drv_note[vi] == 0 || $urandom_range(0, 9) < 3) begin
                k = int'($urandom_range(0, 9));
                if (k == 0)      drv_note[vi] = 0;
                else if (k < 4)  drv_note[vi] = 'h45;
                else if (k < 6)  drv_note[vi] = 'h7F;
                else if (k < 8)  drv_note[vi] = 'h3C;
                else             drv_note[vi] = int'($urandom_range(1, 127));
            end
            k = int'($urandom_range(0, 3));
            if (k == 0)      b = 14'($urandom_range(0, 16383));
            else if (k == 1) b = 14'($urandom_range(0, 63));
            else             b = 14'd0;
            slot(1'($urandom_range(0, 7) != 0), 4'(vi), 7'(drv_note[vi]), b,
                 1'b0, 1'b0, 24'd0, 1'b0);
        end
        slot(1'b0, 4'd0, 7'd0, 14'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        slot(1'b0, 4'd0, 7'd0, 14'd0, 1'b0, 1'b0, 24'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
